pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline. Drives the IF/ID register write-enable
//  and flush, the PC write-enable, ID/EX bubble insertion and a global freeze.
//  Detects load-use hazards, EX-stage redirects (taken branch/jump) and variable-latency data-memory waits.
//  Sequences the post-reset pipeline flush and a memory-wait timeout error.
// PARAMETERS
//  RST_FLUSH_CYC  3    cycles spent flushing after reset release (>=1)
//  MEM_TIMEOUT    255  max consecutive MEM_WAIT cycles before ERROR (>=1)
//  CNT_W          32   width of performance counters
// PORTS
//  clock          in   1   system clock, rising edge
//  reset          in   1   synchronous, active-high reset
//  id_rs          in   5   rs field of instruction in ID
//  id_rt          in   5   rt field of instruction in ID
//  id_uses_rs     in   1   ID instruction reads rs
//  id_uses_rt     in   1   ID instruction reads rt (0 for I-type)
//  ex_mem_read    in   1   instruction in EX is a load
//  ex_rt          in   5   destination reg of load in EX
//  ex_redirect    in   1   taken branch/jump resolved in EX
//  mem_req        in   1   MEM stage holds a load/store
//  mem_ready      in   1   data memory completes the access this cycle
//  pc_write       out  1   PC register enable
//  if_id_write    out  1   IF/ID enable (if_id_write)
//  if_id_flush    out  1   IF/ID flush (if_id_flush)
//  id_ex_bubble   out  1   ID/EX loads a NOP
//  pipe_freeze    out  1   hold ID/EX, EX/MEM, MEM/WB
//  mem_timeout    out  1   sticky error, set on entry to ERROR
//  stall_cnt      out  CNT_W  load-use stall cycles
//  flush_cnt      out  CNT_W  redirect flush cycles
//  wait_cnt       out  CNT_W  memory-wait cycles
// BEHAVIOUR
//  - State register (reset -> RST_FLUSH): RST_FLUSH, RUN, MEM_WAIT, ERROR. Outputs Mealy from state+inputs.
//  - While reset=1 and in RST_FLUSH: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1,
//    pipe_freeze=0, mem_timeout=0, counters=0.
//  - RST_FLUSH: counts RST_FLUSH_CYC cycles after reset deasserts, then -> RUN; inputs ignored.
//  - load_use = ex_mem_read & ex_rt!=0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
//  - RUN priority (highest first):
//    1 mem_req & !mem_ready: pipe_freeze=1, pc_write=0, if_id_write=0, flush=0, bubble=0; -> MEM_WAIT, wait ctr=1.
//    2 ex_redirect: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1 (load_use ignored).
//    3 load_use: pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0. One cycle; no state change.
//    4 else: pc_write=1, if_id_write=1, others 0.
//  - mem_req & mem_ready in RUN: no freeze; rules 2-4 apply.
//  - MEM_WAIT: !mem_ready -> freeze outputs as rule 1; wait ctr++.
//    mem_ready -> freeze released the same cycle, rules 2-4 apply; -> RUN.
//    wait ctr reaching MEM_TIMEOUT with !mem_ready -> ERROR.
//  - ERROR: freeze outputs permanently; mem_timeout=1. Exit only via reset.
//  - Reset mid-MEM_WAIT or in ERROR: next cycle RST_FLUSH, mem_timeout cleared.
//  - Redirect during freeze is not latched; upstream holds it stable until unfrozen.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cnt +1 per rule-3 cycle, flush_cnt +1 per rule-2 cycle,
//    wait_cnt +1 per frozen cycle (MEM_WAIT/ERROR/rule 1). Saturate at all-ones; clear on reset.
//  Undefined: the three counter ports stay but are tied to 0; no counter flops.
// STRUCTURE
//  Package pipe_ctrl_pkg: state enum (RST_FLUSH, RUN, MEM_WAIT, ERROR), REG_ZERO=5'd0, reg-index width 5.
//  Sub-module hazard_perf_cnt: three saturating counters with increment strobes, compiled under the macro.
//  Detection logic and FSM stay in this module.
// TESTING
//  T1 reset 2 cyc, RST_FLUSH_CYC=3 -> flush=1, bubble=1, pc_write=0 for 3 cyc after release; then RUN, pc_write=1.
//  T2 ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 -> 1 cyc pc_write=0, if_id_write=0, bubble=1.
//     Same with ex_rt=0 -> no stall.
//  T3 ex_redirect=1 with load_use true -> flush=1, bubble=1, pc_write=1; stall_cnt unchanged, flush_cnt+1.
//  T4 mem_req=1, mem_ready low 4 cyc then high -> freeze 4 cyc, released on ready cycle; wait_cnt=4.
//  T5 MEM_TIMEOUT=5, mem_ready never -> ERROR after 5 wait cyc, mem_timeout=1 sticky.
//     Reset -> cleared, RST_FLUSH.
//  T6 macro undefined -> counters read 0 through T2-T5.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and register-index helpers.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    MEM_WAIT  = 2'd2,
    ERROR     = 2'd3
  } state_e;

  // Source operand collides with the pending load destination (r0 never collides).
  function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic used,
                                   input logic [REG_W-1:0] dst);
    return used && (dst != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Three saturating event counters (load-use stalls, redirect flushes, memory-wait cycles).
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_inc,
  input  logic             flush_inc,
  input  logic             wait_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counters hold at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    if (wait_inc && (wait_cnt_q != '1))   wait_cnt_d  = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, EX redirect, memory wait, reset flush.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RST_FLUSH_CYC = 3,
  parameter int MEM_TIMEOUT   = 255,
  parameter int CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [1:0]       dbg_state
);

  localparam int FL_W = (RST_FLUSH_CYC > 1) ? $clog2(RST_FLUSH_CYC) : 1;
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(RST_FLUSH_CYC - 1);
  localparam logic [WT_W-1:0] WT_PRE  = WT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [FL_W-1:0]   flush_ctr_q, flush_ctr_d;
  logic [WT_W-1:0]   wait_ctr_q, wait_ctr_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic frozen;
  logic stall_inc, flush_inc, wait_inc;

  assign load_use = ex_mem_read &&
                    (reg_hit(id_rs, id_uses_rs, ex_rt) || reg_hit(id_rt, id_uses_rt, ex_rt));

  // In MEM_WAIT the outstanding access keeps the freeze even if mem_req is dropped.
  assign frozen = ((state_q == RUN) && mem_req && !mem_ready) ||
                  ((state_q == MEM_WAIT) && !mem_ready) ||
                  (state_q == ERROR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RST_FLUSH;
      flush_ctr_q   <= '0;
      wait_ctr_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_ctr_q   <= flush_ctr_d;
      wait_ctr_q    <= wait_ctr_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_ctr_d   = flush_ctr_q;
    wait_ctr_d    = wait_ctr_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RST_FLUSH: begin
        if (flush_ctr_q == FL_LAST) begin
          state_d     = RUN;
          flush_ctr_d = '0;
        end else begin
          flush_ctr_d = flush_ctr_q + 1'b1;
        end
      end
      RUN: begin
        if (frozen) begin
          wait_ctr_d = WT_W'(1);
          if (MEM_TIMEOUT == 1) begin
            state_d       = ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_ctr_q == WT_PRE) begin
          state_d       = ERROR;
          mem_timeout_d = 1'b1;
        end else begin
          wait_ctr_d = wait_ctr_q + 1'b1;
        end
      end
      ERROR: state_d = ERROR;
    endcase
  end

  // Mealy outputs: a released freeze lets redirect/load-use act in the same cycle.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    wait_inc     = 1'b0;
    if (state_q == RST_FLUSH) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (frozen) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_freeze = 1'b1;
      wait_inc    = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign dbg_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clock     (clock),
    .reset     (reset),
    .stall_inc (stall_inc),
    .flush_inc (flush_inc),
    .wait_inc  (wait_inc),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .wait_cnt  (wait_cnt)
  );
`else
  logic unused_inc;
  assign unused_inc = stall_inc ^ flush_inc ^ wait_inc;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
  assign wait_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus a random run
// checked every cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int RST_CYC = 3;
  localparam int TMO     = 5;
  localparam int CW      = 8;
  localparam int CMAX    = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // clock/reset and DUT signals
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.RST_FLUSH_CYC(RST_CYC), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt), .dbg_state(dbg_state)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: pipeline condition tracked as plain flags and cycle counts
  bit m_flushing = 1'b1;
  int m_flush_done = 0;
  bit m_waiting = 1'b0;
  int m_wait_len = 0;
  bit m_error = 1'b0;
  int m_stall = 0, m_flush = 0, m_wait = 0;
  bit lu, frz;
  logic e_pc, e_ifid, e_fl, e_bub, e_frz;

  // scoreboard: one comparison pass per cycle, mid-cycle, then advance the model
  initial begin
    forever begin
      @(negedge clock);
      if (armed && !done) begin
        lu = ex_mem_read && ex_rt != 0 &&
             ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
        frz = m_error || (!m_flushing && !mem_ready && (m_waiting || mem_req));
        {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b11000;
        if (m_flushing)       {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b00110;
        else if (frz)         {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b00001;
        else if (ex_redirect) {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b11110;
        else if (lu)          {e_pc, e_ifid, e_fl, e_bub, e_frz} = 5'b00010;
        chk("pc_write", pc_write, e_pc);
        chk("if_id_write", if_id_write, e_ifid);
        chk("if_id_flush", if_id_flush, e_fl);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("pipe_freeze", pipe_freeze, e_frz);
        chk("mem_timeout", mem_timeout, m_error);
        chk("stall_cnt", stall_cnt, PERF ? m_stall : 0);
        chk("flush_cnt", flush_cnt, PERF ? m_flush : 0);
        chk("wait_cnt", wait_cnt, PERF ? m_wait : 0);
        if (reset) begin
          m_flushing = 1'b1; m_flush_done = 0; m_waiting = 1'b0; m_wait_len = 0;
          m_error = 1'b0; m_stall = 0; m_flush = 0; m_wait = 0;
        end else if (m_error) begin
          if (m_wait < CMAX) m_wait++;
        end else if (m_flushing) begin
          m_flush_done++;
          if (m_flush_done == RST_CYC) m_flushing = 1'b0;
        end else if (frz) begin
          m_wait_len = m_waiting ? m_wait_len + 1 : 1;
          m_waiting  = 1'b1;
          if (m_wait < CMAX) m_wait++;
          if (m_wait_len >= TMO) begin
            m_error   = 1'b1;
            m_waiting = 1'b0;
          end
        end else begin
          m_waiting = 1'b0;
          if (ex_redirect) begin
            if (m_flush < CMAX) m_flush++;
          end else if (lu) begin
            if (m_stall < CMAX) m_stall++;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use_in(input logic [4:0] dst);
    ex_mem_read = 1'b1; ex_rt = dst; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    armed = 1'b1;
    step();
    reset = 1'b0;
    // post-reset flush: three cycles, then normal fetch
    for (int k = 0; k < RST_CYC; k++) begin
      @(negedge clock);
      chk("t1_flush", if_id_flush, 1);
      chk("t1_pc_hold", pc_write, 0);
      step();
    end
    @(negedge clock);
    chk("t1_run_pc", pc_write, 1);
    chk("t1_run_flush", if_id_flush, 0);
    // load-use stall, then the same with r0 as destination
    step(); load_use_in(5'd8);
    @(negedge clock);
    chk("t2_pc", pc_write, 0);
    chk("t2_ifid", if_id_write, 0);
    chk("t2_bubble", id_ex_bubble, 1);
    step(); ex_rt = 5'd0;
    @(negedge clock);
    chk("t2_r0_pc", pc_write, 1);
    chk("t2_r0_bubble", id_ex_bubble, 0);
    step(); idle();
    @(negedge clock);
    chk("t2_stall_cnt", stall_cnt, PERF ? 1 : 0);
    // redirect overrides load-use
    step(); load_use_in(5'd8); ex_redirect = 1'b1;
    @(negedge clock);
    chk("t3_flush", if_id_flush, 1);
    chk("t3_bubble", id_ex_bubble, 1);
    chk("t3_pc", pc_write, 1);
    step(); idle();
    @(negedge clock);
    chk("t3_flush_cnt", flush_cnt, PERF ? 1 : 0);
    chk("t3_stall_cnt", stall_cnt, PERF ? 1 : 0);
    // four-cycle memory wait, released on the ready cycle
    for (int k = 0; k < 4; k++) begin
      step(); mem_req = 1'b1; mem_ready = 1'b0;
      @(negedge clock);
      chk("t4_freeze", pipe_freeze, 1);
      chk("t4_pc", pc_write, 0);
    end
    step(); mem_ready = 1'b1;
    @(negedge clock);
    chk("t4_release", pipe_freeze, 0);
    chk("t4_release_pc", pc_write, 1);
    step(); idle();
    @(negedge clock);
    chk("t4_wait_cnt", wait_cnt, PERF ? 4 : 0);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step();
      reset       = ($urandom_range(0, 249) == 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rt       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 4) == 0);
      mem_req     = 1'($urandom_range(0, 1));
      mem_ready   = ($urandom_range(0, 3) != 0);
    end
    // memory timeout into the sticky error state, then recovery by reset
    step(); idle(); reset = 1'b1;
    step(); reset = 1'b0;
    step(); step(); step();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clock);
      chk("t5_wait_freeze", pipe_freeze, 1);
      chk("t5_no_err_yet", mem_timeout, 0);
      step();
    end
    @(negedge clock);
    chk("t5_err", mem_timeout, 1);
    step(); mem_req = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    chk("t5_err_sticky", mem_timeout, 1);
    chk("t5_err_freeze", pipe_freeze, 1);
    for (int k = 0; k < 300; k++) step();
    @(negedge clock);
    chk("t5_wait_sat", wait_cnt, PERF ? CMAX : 0);
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clock);
    chk("t5_err_clr", mem_timeout, 0);
    chk("t5_reflush", if_id_flush, 1);
    chk("t5_wait_clr", wait_cnt, 0);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
